// File: rtl/haz_pkg.sv
// Shared types and helpers for the hazard resolver.
//   haz_state_t : resolver FSM state encoding (also exported on the debug port)
//   fwd_sel_w   : width of a forwarding select (0 = regfile, k+1 = stage k)
package haz_pkg;

  typedef enum logic [1:0] {
    NORM   = 2'd0,
    DSTALL = 2'd1,
    SSTALL = 2'd2,
    FLUSH  = 2'd3
  } haz_state_t;

  function automatic int fwd_sel_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/haz_resolver_param_if.sv
// Bundle between ID / pipeline control and the hazard resolver.
//   master : pipeline side, drives operand/stage/branch/structural info
//   slave  : resolver side, drives stall, flush, forwarding and status
interface haz_resolver_param_if import haz_pkg::*; #(
  parameter int REG_AW      = 5,
  parameter int FWD_STAGES  = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int STAT_W      = 16
);
  localparam int SEL_W = fwd_sel_w(FWD_STAGES);

  logic [REG_AW-1:0]            id_rs1;
  logic [REG_AW-1:0]            id_rs2;
  logic                         id_rs1_used;
  logic                         id_rs2_used;
  logic [FWD_STAGES*REG_AW-1:0] stg_rd;
  logic [FWD_STAGES-1:0]        stg_wr_en;
  logic [FWD_STAGES-1:0]        stg_is_load;
  logic                         fwd_en;
  logic                         br_valid;
  logic                         br_mispredict;
  logic                         str_req;

  logic                         pc_freeze;
  logic                         if_id_hold;
  logic                         id_ex_bubble;
  logic [FLUSH_DEPTH-1:0]       flush;
  logic [SEL_W-1:0]             fwd_sel_rs1;
  logic [SEL_W-1:0]             fwd_sel_rs2;
  logic                         resolved;
  logic                         str_timeout;
  logic [STAT_W-1:0]            stall_cycles;
  logic [1:0]                   state;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, stg_rd, stg_wr_en,
           stg_is_load, fwd_en, br_valid, br_mispredict, str_req,
    input  pc_freeze, if_id_hold, id_ex_bubble, flush, fwd_sel_rs1,
           fwd_sel_rs2, resolved, str_timeout, stall_cycles, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, stg_rd, stg_wr_en,
           stg_is_load, fwd_en, br_valid, br_mispredict, str_req,
    output pc_freeze, if_id_hold, id_ex_bubble, flush, fwd_sel_rs1,
           fwd_sel_rs2, resolved, str_timeout, stall_cycles, state
  );

endinterface

// File: rtl/haz_fwd_match.sv
// Per-operand register-address compare against downstream stages plus a
// priority encoder that picks the nearest matching stage.
//   rs, used         : source register and its valid
//   stg_rd/stg_wr_en : packed destinations / write enables, stage 0 nearest
//   match            : per-stage match vector
//   sel              : 0 = no match, k+1 = lowest matching stage k
module haz_fwd_match #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_AW-1:0]            rs,
  input  logic                         used,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]        stg_wr_en,
  output logic [FWD_STAGES-1:0]        match,
  output logic [SEL_W-1:0]             sel
);

  // x0 is hardwired zero, so a write to it never produces a hazard.
  always_comb begin
    match = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      match[k] = used && stg_wr_en[k] &&
                 (stg_rd[k*REG_AW +: REG_AW] != '0) &&
                 (stg_rd[k*REG_AW +: REG_AW] == rs);
    end
  end

  // Walk from the farthest stage down so the nearest (youngest) value wins.
  always_comb begin
    sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (match[k]) sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/haz_resolver_param.sv
// Hazard resolver between ID and the pipeline control registers.
// Ports: clk, rst (sync, active-high), bus (haz_resolver_param_if.slave).
//
// state  | meaning
// NORM   | no action pending; hazards evaluated fresh each cycle
// DSTALL | data stall: load-use countdown or wait-for-writeback (nf mode)
// SSTALL | structural stall, timeout counter running
// FLUSH  | one-cycle front-end flush after a mispredict
module haz_resolver_param import haz_pkg::*; #(
  parameter int REG_AW      = 5,
  parameter int FWD_STAGES  = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int STO_W       = 4,
  parameter int STAT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  haz_resolver_param_if.slave bus
);

  localparam int SEL_W = fwd_sel_w(FWD_STAGES);
  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) + 1 : 1;
  // Last count before the counter would hit all-ones.
  localparam logic [STO_W-1:0] STO_LAST = STO_W'((1 << STO_W) - 2);

  logic [FWD_STAGES-1:0] m_rs1, m_rs2;
  logic [SEL_W-1:0]      sel_rs1, sel_rs2;

  haz_fwd_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_match_rs1 (
    .rs(bus.id_rs1), .used(bus.id_rs1_used), .stg_rd(bus.stg_rd),
    .stg_wr_en(bus.stg_wr_en), .match(m_rs1), .sel(sel_rs1)
  );

  haz_fwd_match #(.REG_AW(REG_AW), .FWD_STAGES(FWD_STAGES), .SEL_W(SEL_W)) u_match_rs2 (
    .rs(bus.id_rs2), .used(bus.id_rs2_used), .stg_rd(bus.stg_rd),
    .stg_wr_en(bus.stg_wr_en), .match(m_rs2), .sel(sel_rs2)
  );

  // Only the EX stage load flag matters; deeper stages already have data.
  logic unused_is_load;
  assign unused_is_load = ^bus.stg_is_load;

  logic mis, lu, nf;
  assign mis = bus.br_valid && bus.br_mispredict;
  assign lu  = bus.fwd_en && bus.stg_is_load[0] && (m_rs1[0] || m_rs2[0]);
  assign nf  = !bus.fwd_en && ((|m_rs1) || (|m_rs2));

  haz_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nf_mode_q, nf_mode_d;
  logic [STO_W-1:0]  sto_cnt_q, sto_cnt_d;
  logic              str_timeout_q;
  logic [STAT_W-1:0] stall_cycles_q;
  logic              timeout_set, stall, resolved, eval_norm;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nf_mode_d   = nf_mode_q;
    sto_cnt_d   = sto_cnt_q;
    timeout_set = 1'b0;
    stall       = 1'b0;
    resolved    = 1'b0;
    eval_norm   = 1'b0;

    if (mis) begin
      state_d = FLUSH;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        NORM: eval_norm = 1'b1;
        DSTALL: begin
          if (bus.str_req) begin
            stall     = 1'b1;
            state_d   = SSTALL;
            sto_cnt_d = STO_W'(1);
          end else if (nf_mode_q) begin
            if (nf) begin
              stall = 1'b1;
            end else begin
              resolved = 1'b1;
              state_d  = NORM;
            end
          end else begin
            stall = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = NORM;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        SSTALL: begin
          if (bus.str_req) begin
            stall     = 1'b1;
            sto_cnt_d = sto_cnt_q + STO_W'(1);
            if (sto_cnt_q == STO_LAST) begin
              timeout_set = 1'b1;
              state_d     = NORM;
            end
          end else begin
            // Resource freed: this cycle behaves exactly like NORM.
            eval_norm = 1'b1;
          end
        end
        FLUSH: state_d = NORM;
        default: state_d = NORM;
      endcase
    end

    if (eval_norm) begin
      state_d = NORM;
      if (bus.str_req) begin
        stall     = 1'b1;
        state_d   = SSTALL;
        sto_cnt_d = STO_W'(1);
      end else if (lu) begin
        stall     = 1'b1;
        nf_mode_d = 1'b0;
        cnt_d     = CNT_W'(LOAD_LAT - 1);
        state_d   = (LOAD_LAT > 1) ? DSTALL : NORM;
      end else if (nf) begin
        stall     = 1'b1;
        nf_mode_d = 1'b1;
        state_d   = DSTALL;
      end else begin
        resolved = 1'b1;
      end
    end

    // Outputs idle while reset is held so nothing leaks into the pipeline.
    if (rst) begin
      stall    = 1'b0;
      resolved = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= NORM;
      cnt_q          <= '0;
      nf_mode_q      <= 1'b0;
      sto_cnt_q      <= '0;
      str_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nf_mode_q <= nf_mode_d;
      sto_cnt_q <= sto_cnt_d;
      if (timeout_set) str_timeout_q <= 1'b1;
      if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + STAT_W'(1);
    end
  end

  assign bus.pc_freeze    = stall;
  assign bus.if_id_hold   = stall;
  assign bus.id_ex_bubble = stall;
  assign bus.flush        = ((state_q == FLUSH) && !rst) ? '1 : '0;
  assign bus.fwd_sel_rs1  = bus.fwd_en ? sel_rs1 : '0;
  assign bus.fwd_sel_rs2  = bus.fwd_en ? sel_rs2 : '0;
  assign bus.resolved     = resolved;
  assign bus.str_timeout  = str_timeout_q;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_haz_resolver_param.sv
module tb_haz_resolver_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  haz_resolver_param_if #(.REG_AW(5), .FWD_STAGES(2), .FLUSH_DEPTH(2), .STAT_W(4)) bus ();

  haz_resolver_param #(
    .REG_AW(5), .FWD_STAGES(2), .LOAD_LAT(2), .FLUSH_DEPTH(2), .STO_W(4), .STAT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic       fe;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd0, rd1;
    logic [1:0] we, ld;
    logic [1:0] sel1, sel2;
    logic       stl, res;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.stg_rd = '0; bus.stg_wr_en = '0; bus.stg_is_load = '0; bus.fwd_en = 1;
    bus.br_valid = 0; bus.br_mispredict = 0; bus.str_req = 0;
  endtask

  task automatic drive(input vec_t v);
    bus.fwd_en = v.fe; bus.id_rs1 = v.rs1; bus.id_rs2 = v.rs2;
    bus.id_rs1_used = v.u1; bus.id_rs2_used = v.u2;
    bus.stg_rd = {v.rd1, v.rd0}; bus.stg_wr_en = v.we; bus.stg_is_load = v.ld;
    bus.br_valid = 0; bus.br_mispredict = 0; bus.str_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle();
    #1;
    chk("rst_resolved", bus.resolved, 1);
    chk("rst_stall", bus.pc_freeze, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_state", bus.state, 0);
    chk("post_rst_stat", bus.stall_cycles, 0);
    chk("post_rst_sto", bus.str_timeout, 0);
    chk("post_rst_flush", bus.flush, 0);
  endtask

  task automatic load_hazard();
    bus.fwd_en = 1; bus.stg_rd = {5'd0, 5'd5}; bus.stg_wr_en = 2'b01;
    bus.stg_is_load = 2'b01; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1;
  endtask

  initial begin
    //           fe  rs1    rs2    u1 u2 rd0    rd1    we     ld     sel1  sel2  stl res
    vecs[0]  = '{1, 5'd1, 5'd7, 1, 1, 5'd0, 5'd7, 2'b10, 2'b00, 2'd0, 2'd2, 0, 1};
    vecs[1]  = '{1, 5'd1, 5'd0, 1, 1, 5'd0, 5'd0, 2'b10, 2'b00, 2'd0, 2'd0, 0, 1};
    vecs[2]  = '{1, 5'd4, 5'd0, 1, 0, 5'd4, 5'd4, 2'b11, 2'b00, 2'd1, 2'd0, 0, 1};
    vecs[3]  = '{1, 5'd4, 5'd0, 1, 0, 5'd4, 5'd4, 2'b10, 2'b00, 2'd2, 2'd0, 0, 1};
    vecs[4]  = '{1, 5'd4, 5'd4, 0, 1, 5'd4, 5'd0, 2'b01, 2'b00, 2'd0, 2'd1, 0, 1};
    vecs[5]  = '{1, 5'd2, 5'd9, 1, 1, 5'd9, 5'd0, 2'b01, 2'b01, 2'd0, 2'd1, 1, 0};
    vecs[6]  = '{1, 5'd9, 5'd3, 1, 1, 5'd0, 5'd9, 2'b10, 2'b10, 2'd2, 2'd0, 0, 1};
    vecs[7]  = '{0, 5'd6, 5'd1, 1, 1, 5'd0, 5'd6, 2'b10, 2'b00, 2'd0, 2'd0, 1, 0};
    vecs[8]  = '{0, 5'd6, 5'd1, 1, 1, 5'd2, 5'd3, 2'b11, 2'b00, 2'd0, 2'd0, 0, 1};
    vecs[9]  = '{1, 5'd9, 5'd0, 1, 0, 5'd9, 5'd0, 2'b00, 2'b01, 2'd0, 2'd0, 0, 1};
    vecs[10] = '{0, 5'd5, 5'd5, 0, 0, 5'd5, 5'd5, 2'b11, 2'b00, 2'd0, 2'd0, 0, 1};
    vecs[11] = '{1, 5'd5, 5'd0, 0, 1, 5'd5, 5'd0, 2'b01, 2'b01, 2'd0, 2'd0, 0, 1};

    idle();
    do_reset();

    // Single-cycle vectors from NORM; a reset between vectors returns to NORM.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_sel1", i), bus.fwd_sel_rs1, vecs[i].sel1);
      chk($sformatf("v%0d_sel2", i), bus.fwd_sel_rs2, vecs[i].sel2);
      chk($sformatf("v%0d_pc_freeze", i), bus.pc_freeze, vecs[i].stl);
      chk($sformatf("v%0d_if_id_hold", i), bus.if_id_hold, vecs[i].stl);
      chk($sformatf("v%0d_bubble", i), bus.id_ex_bubble, vecs[i].stl);
      chk($sformatf("v%0d_resolved", i), bus.resolved, vecs[i].res);
      chk($sformatf("v%0d_flush", i), bus.flush, 0);
      rst = 1;
      @(negedge clk);
      rst = 0;
    end

    // Load-use with LOAD_LAT=2: exactly two stall cycles.
    do_reset();
    load_hazard();
    #1 chk("lu_c0_stall", bus.pc_freeze, 1);
    chk("lu_c0_res", bus.resolved, 0);
    @(negedge clk); #1;
    chk("lu_c1_stall", bus.pc_freeze, 1);
    chk("lu_c1_state", bus.state, 1);
    @(negedge clk);
    bus.stg_is_load = 2'b00;
    #1;
    chk("lu_c2_stall", bus.pc_freeze, 0);
    chk("lu_c2_res", bus.resolved, 1);
    chk("lu_c2_sel1", bus.fwd_sel_rs1, 1);
    chk("lu_c2_stat", bus.stall_cycles, 2);
    chk("lu_c2_state", bus.state, 0);

    // No-forwarding mode: hazard walks from stage 0 to stage 1, then clears.
    do_reset();
    bus.fwd_en = 0; bus.id_rs1 = 5'd3; bus.id_rs1_used = 1;
    bus.stg_rd = {5'd0, 5'd3}; bus.stg_wr_en = 2'b01;
    #1 chk("nf_c0_stall", bus.pc_freeze, 1);
    chk("nf_c0_sel", bus.fwd_sel_rs1, 0);
    @(negedge clk);
    bus.stg_rd = {5'd3, 5'd0}; bus.stg_wr_en = 2'b10;
    #1 chk("nf_c1_stall", bus.pc_freeze, 1);
    chk("nf_c1_state", bus.state, 1);
    chk("nf_c1_sel", bus.fwd_sel_rs1, 0);
    @(negedge clk);
    bus.stg_wr_en = 2'b00;
    #1 chk("nf_c2_stall", bus.pc_freeze, 0);
    chk("nf_c2_res", bus.resolved, 1);
    @(negedge clk); #1;
    chk("nf_c3_state", bus.state, 0);
    chk("nf_c3_stat", bus.stall_cycles, 2);

    // Mispredict in DSTALL (cnt=1), repeat in FLUSH, then back to NORM.
    do_reset();
    load_hazard();
    #1 chk("mp_c0_stall", bus.pc_freeze, 1);
    @(negedge clk);
    bus.br_valid = 1; bus.br_mispredict = 1;
    #1 chk("mp_c1_state", bus.state, 1);
    chk("mp_c1_stall", bus.pc_freeze, 0);
    chk("mp_c1_res", bus.resolved, 0);
    chk("mp_c1_flush", bus.flush, 0);
    @(negedge clk);
    idle();
    bus.br_valid = 1; bus.br_mispredict = 1;
    #1 chk("mp_c2_state", bus.state, 3);
    chk("mp_c2_flush", bus.flush, 2'b11);
    chk("mp_c2_stall", bus.pc_freeze, 0);
    chk("mp_c2_res", bus.resolved, 0);
    @(negedge clk);
    bus.br_valid = 0; bus.br_mispredict = 0;
    #1 chk("mp_c3_state", bus.state, 3);
    chk("mp_c3_flush", bus.flush, 2'b11);
    @(negedge clk); #1;
    chk("mp_c4_state", bus.state, 0);
    chk("mp_c4_flush", bus.flush, 0);
    chk("mp_c4_res", bus.resolved, 1);
    chk("mp_c4_stat", bus.stall_cycles, 1);

    // Structural request held 20 cycles: timeout after 15 stall cycles,
    // stall count saturates at 15 with STAT_W=4.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.str_req = 1;
      #1;
      chk($sformatf("st%0d_stall", i), bus.pc_freeze, 1);
      chk($sformatf("st%0d_sto", i), bus.str_timeout, (i >= 15) ? 1 : 0);
      chk($sformatf("st%0d_stat", i), bus.stall_cycles, (i < 15) ? i : 15);
      chk($sformatf("st%0d_state", i), bus.state, (i == 0 || i == 15) ? 0 : 2);
      @(negedge clk);
    end
    bus.str_req = 0;
    #1 chk("st_drop_stall", bus.pc_freeze, 0);
    chk("st_drop_res", bus.resolved, 1);
    chk("st_drop_state", bus.state, 2);
    @(negedge clk); #1;
    chk("st_after_state", bus.state, 0);
    chk("st_after_sto", bus.str_timeout, 1);
    chk("st_after_stat", bus.stall_cycles, 15);
    @(negedge clk); #1;
    chk("st_sticky_sto", bus.str_timeout, 1);

    // Reset during SSTALL aborts immediately.
    bus.str_req = 1;
    #1 chk("rs_c0_stall", bus.pc_freeze, 1);
    @(negedge clk); #1;
    chk("rs_c1_state", bus.state, 2);
    rst = 1;
    #1 chk("rs_c1_gated_stall", bus.pc_freeze, 0);
    chk("rs_c1_gated_res", bus.resolved, 1);
    @(negedge clk);
    rst = 0; bus.str_req = 0;
    #1 chk("rs_c2_state", bus.state, 0);
    chk("rs_c2_sto", bus.str_timeout, 0);
    chk("rs_c2_stat", bus.stall_cycles, 0);
    chk("rs_c2_res", bus.resolved, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/haz_resolver_param.md
Name: haz_resolver_param

Overview:
- Parametrised successor of the single-hazard FSM resolver for the in-order core.
- Sits between ID and the pipeline control registers.
- Detects RAW hazards by register-address compare against FWD_STAGES downstream stages, and generates forwarding selects.
- Enforces load-use and no-forwarding stalls, structural stalls with timeout, and branch-mispredict flushes. Keeps a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register address width.
- FWD_STAGES, 2, number of downstream stages compared; stage 0 is the nearest (EX).
- LOAD_LAT, 1, stall cycles per load-use hazard (>=1).
- FLUSH_DEPTH, 2, number of front-end stages flushed on mispredict.
- STO_W, 4, structural-timeout counter width; timeout is 2^STO_W-1 cycles.
- STAT_W, 16, stall statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_rs1, id_rs2  in  REG_AW each  ID source registers.
- id_rs1_used, id_rs2_used  in  1 each  source valid.
- stg_rd  in  FWD_STAGES*REG_AW  destination per stage; stage k occupies bits [k*REG_AW +: REG_AW].
- stg_wr_en  in  FWD_STAGES  stage writes a register.
- stg_is_load  in  FWD_STAGES  stage holds a load (only bit 0 is used).
- fwd_en  in  1  mode: 1 = forwarding enabled, 0 = stall until writeback.
- br_valid, br_mispredict  in  1 each  branch resolved in EX, mispredicted.
- str_req  in  1  structural resource busy.
- pc_freeze  out  1  hold PC.
- if_id_hold  out  1  hold IF/ID register.
- id_ex_bubble  out  1  inject NOP into ID/EX.
- flush  out  FLUSH_DEPTH  per-stage flush.
- fwd_sel_rs1, fwd_sel_rs2  out  $clog2(FWD_STAGES+1) each  0 = register file, k+1 = stage k.
- resolved  out  1  no hazard action this cycle.
- str_timeout  out  1  sticky structural timeout error.
- stall_cycles  out  STAT_W  saturating stall count.
- state  out  2  debug: current FSM state.

Behaviour:
- Match rule. match_k(rs) = used && stg_wr_en[k] && stg_rd[k]!=0 && stg_rd[k]==rs. Combinational.
- Forwarding select. fwd_sel is the lowest matching k, plus 1. If fwd_en=0, fwd_sel is forced to 0.
- Hazard conditions.
  - lu = fwd_en && stg_is_load[0] && (match_0(rs1) || match_0(rs2)).
  - nf = !fwd_en && any match.
- States: NORM=0, DSTALL=1, SSTALL=2, FLUSH=3. The state register is updated on clk. Stall outputs are Mealy, so the stall takes effect in the detection cycle.
- stall = pc_freeze = if_id_hold = id_ex_bubble.
- Priority in every state: mispredict > structural > data.
  - mispredict means br_valid && br_mispredict.
  - A mispredict in any state gives ns=FLUSH, clears the data counter, and stall=0 that cycle.
- NORM:
  - str_req: stall=1, ns=SSTALL, sto_cnt<=1.
  - Else lu: stall=1, cnt<=LOAD_LAT-1, ns = DSTALL if LOAD_LAT>1, else NORM.
  - Else nf: stall=1, ns=DSTALL.
  - Else resolved=1.
- DSTALL:
  - stall=1.
  - In lu mode, cnt decrements; the cycle with cnt==1 is the last stall cycle, then ns=NORM.
  - In nf mode, stay while any match; when no match, stall=0, resolved=1, ns=NORM.
  - A load-use hazard therefore costs exactly LOAD_LAT stall cycles.
- SSTALL:
  - stall=1 while str_req; sto_cnt increments each cycle.
  - When sto_cnt reaches all-ones, str_timeout<=1 (sticky until rst) and ns=NORM.
  - When str_req drops, the cycle is evaluated as NORM (data hazards re-checked), and ns follows the NORM rules.
- FLUSH: lasts one cycle.
  - flush={FLUSH_DEPTH{1}}, stall=0, resolved=0.
  - ns=NORM, unless a new mispredict arrives, then stay in FLUSH.
- flush=0 outside FLUSH.
- stall_cycles: +1 on each cycle with stall=1; saturates at all-ones with no wrap.
- Reset values: state=NORM; cnt, sto_cnt, stall_cycles, str_timeout all 0. All outputs are 0 except resolved=1 and fwd_sel, which is combinational from inputs.
- Reset mid-stall or mid-flush aborts immediately. The next cycle is NORM.
- Register 0 never matches.

Decomposition:
- Package haz_pkg holds the state enum (NORM/DSTALL/SSTALL/FLUSH) and the fwd_sel width function.
- One sub-module: haz_fwd_match, combinational match and priority encoder, instantiated once per source operand.

Test Plan:
- LOAD_LAT=2, stage0 load rd=5, id_rs1=5: stall=1 for exactly 2 cycles, then resolved=1 and fwd_sel_rs1=1; stall_cycles=2.
- fwd_en=1, stage1 rd=7 (no load), id_rs2=7: no stall, fwd_sel_rs2=2. Same with stg_rd=0: fwd_sel_rs2=0.
- fwd_en=0, stage0 rd=3 then stage1 rd=3 over 2 cycles, then none: stall for 2 cycles, fwd_sel=0, resolved in cycle 3.
- In DSTALL with cnt=1, assert mispredict: the next cycle is FLUSH with flush=2'b11 and stall=0; NORM follows.
- str_req held for 20 cycles (STO_W=4): str_timeout=1 after 15 stall cycles, and it stays 1 until rst. stall_cycles saturates correctly with STAT_W=4.
- Assert rst during SSTALL: the next cycle has state=NORM, str_timeout=0, stall_cycles=0.
